// File: rtl/kch_sequencer.sv
// Sequences the known-cluster-head table through one election round: clears it on a heartbeat,
// feeds it accepted CH advertisements one strobe at a time, and reports the table's choice.
module kch_sequencer #(
  parameter int unsigned WORD_WIDTH      = 16,
  parameter int unsigned HB_RESET_CYCLES = 2,
  parameter int unsigned WINDOW_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [1:0]            pkt_type,
  input  logic [WORD_WIDTH-1:0] pkt_chlimit,
  input  logic [WORD_WIDTH-1:0] pkt_src,
  input  logic [WORD_WIDTH-1:0] pkt_hops,
  input  logic [WORD_WIDTH-1:0] pkt_qvalue,
  output logic                  HB_reset,
  output logic [WORD_WIDTH-1:0] HB_CHlimit,
  output logic                  en_KCH,
  output logic [WORD_WIDTH-1:0] fCH_ID,
  output logic [WORD_WIDTH-1:0] fCH_Hops,
  output logic [WORD_WIDTH-1:0] fCH_QValue,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsfromCH,
  output logic                  sel_valid,
  output logic [WORD_WIDTH-1:0] sel_id,
  output logic [WORD_WIDTH-1:0] sel_hops,
  output logic                  sel_none,
  output logic                  busy
);

  typedef enum logic [2:0] {
    StIdle,
    StHbClr,
    StCollect,
    StLoad,
    StStrobe,
    StSettle,
    StReport
  } state_e;

  localparam logic [1:0]            PktHb      = 2'b01;
  localparam logic [1:0]            PktAdv     = 2'b10;
  localparam logic [WORD_WIDTH-1:0] AllOnes    = '1;
  localparam logic [WORD_WIDTH-1:0] One        = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]            HbLast     = 4'(HB_RESET_CYCLES);
  localparam logic [3:0]            SettleLast = 4'(SETTLE_CYCLES);
  localparam logic [15:0]           WinLast    = 16'(WINDOW_CYCLES);

  state_e                state_q, state_d;
  logic [3:0]            cyc_q, cyc_d;
  logic [15:0]           win_q, win_d;
  logic [WORD_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pkt_ready_q, pkt_ready_d;
  logic                  hb_reset_q, hb_reset_d;
  logic [WORD_WIDTH-1:0] limit_q, limit_d;
  logic                  en_q, en_d;
  logic [WORD_WIDTH-1:0] fch_id_q, fch_id_d;
  logic [WORD_WIDTH-1:0] fch_hops_q, fch_hops_d;
  logic [WORD_WIDTH-1:0] fch_qvalue_q, fch_qvalue_d;
  logic                  sel_valid_q, sel_valid_d;
  logic [WORD_WIDTH-1:0] sel_id_q, sel_id_d;
  logic [WORD_WIDTH-1:0] sel_hops_q, sel_hops_d;
  logic                  sel_none_q, sel_none_d;
  logic                  busy_q, busy_d;

  logic                  fire;
  logic                  start_hb;
  logic [15:0]           win_inc;
  logic                  win_last;
  logic [WORD_WIDTH-1:0] cnt_inc;

  assign fire     = pkt_valid & pkt_ready_q;
  // Window timer saturates; win_last marks the final (or any later) window cycle.
  assign win_inc  = (win_q == WinLast) ? win_q : win_q + 16'd1;
  assign win_last = (win_inc == WinLast);
  assign cnt_inc  = cnt_q + One;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    limit_d      = limit_q;
    fch_id_d     = fch_id_q;
    fch_hops_d   = fch_hops_q;
    fch_qvalue_d = fch_qvalue_q;
    sel_id_d     = sel_id_q;
    sel_hops_d   = sel_hops_q;
    sel_none_d   = sel_none_q;
    pkt_ready_d  = 1'b0;
    hb_reset_d   = 1'b0;
    en_d         = 1'b0;
    sel_valid_d  = 1'b0;
    busy_d       = 1'b1;
    start_hb     = 1'b0;

    unique case (state_q)
      StIdle: begin
        pkt_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (fire && (pkt_type == PktHb)) begin
          start_hb = 1'b1;
        end
      end

      StHbClr: begin
        if (cyc_q == HbLast) begin
          cyc_d = 4'd1;
          if (limit_q == '0) begin
            state_d = StSettle;
          end else begin
            state_d     = StCollect;
            pkt_ready_d = 1'b1;
          end
        end else begin
          hb_reset_d = 1'b1;
          cyc_d      = cyc_q + 4'd1;
        end
      end

      StCollect: begin
        win_d = win_inc;
        // A packet handshaken in the last window cycle still takes priority over closing.
        if (fire && (pkt_type == PktHb)) begin
          start_hb = 1'b1;
        end else if (fire && (pkt_type == PktAdv) && (pkt_hops != AllOnes)) begin
          fch_id_d     = pkt_src;
          fch_hops_d   = pkt_hops;
          fch_qvalue_d = pkt_qvalue;
          state_d      = StLoad;
        end else if (win_last) begin
          state_d = StSettle;
          cyc_d   = 4'd1;
        end else begin
          pkt_ready_d = 1'b1;
        end
      end

      StLoad: begin
        win_d   = win_inc;
        en_d    = 1'b1;
        state_d = StStrobe;
      end

      StStrobe: begin
        win_d = win_inc;
        cnt_d = cnt_inc;
        if ((cnt_inc == limit_q) || win_last) begin
          state_d = StSettle;
          cyc_d   = 4'd1;
        end else begin
          state_d     = StCollect;
          pkt_ready_d = 1'b1;
        end
      end

      StSettle: begin
        if (cyc_q == SettleLast) begin
          sel_none_d  = (cnt_q == '0);
          sel_id_d    = (cnt_q == '0) ? AllOnes : chosenCH;
          sel_hops_d  = (cnt_q == '0) ? AllOnes : hopsfromCH;
          sel_valid_d = 1'b1;
          state_d     = StReport;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end

      StReport: begin
        state_d     = StIdle;
        pkt_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // A heartbeat (from IDLE or mid-collection) opens a fresh round.
    if (start_hb) begin
      state_d     = StHbClr;
      hb_reset_d  = 1'b1;
      limit_d     = pkt_chlimit;
      cnt_d       = '0;
      win_d       = '0;
      cyc_d       = 4'd1;
      pkt_ready_d = 1'b0;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cyc_q        <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      pkt_ready_q  <= 1'b0;
      hb_reset_q   <= 1'b0;
      limit_q      <= '0;
      en_q         <= 1'b0;
      fch_id_q     <= '0;
      fch_hops_q   <= '1;
      fch_qvalue_q <= '0;
      sel_valid_q  <= 1'b0;
      sel_id_q     <= '0;
      sel_hops_q   <= '0;
      sel_none_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      pkt_ready_q  <= pkt_ready_d;
      hb_reset_q   <= hb_reset_d;
      limit_q      <= limit_d;
      en_q         <= en_d;
      fch_id_q     <= fch_id_d;
      fch_hops_q   <= fch_hops_d;
      fch_qvalue_q <= fch_qvalue_d;
      sel_valid_q  <= sel_valid_d;
      sel_id_q     <= sel_id_d;
      sel_hops_q   <= sel_hops_d;
      sel_none_q   <= sel_none_d;
      busy_q       <= busy_d;
    end
  end

  assign pkt_ready  = pkt_ready_q;
  assign HB_reset   = hb_reset_q;
  assign HB_CHlimit = limit_q;
  assign en_KCH     = en_q;
  assign fCH_ID     = fch_id_q;
  assign fCH_Hops   = fch_hops_q;
  assign fCH_QValue = fch_qvalue_q;
  assign sel_valid  = sel_valid_q;
  assign sel_id     = sel_id_q;
  assign sel_hops   = sel_hops_q;
  assign sel_none   = sel_none_q;
  assign busy       = busy_q;

endmodule
